// File: rtl/ssd1306_pkg.sv
// SSD1306 opcode map, addressing-mode and decoder-state types shared by the init and sink paths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ssd1306_pkg;

  localparam logic [7:0] CMD_SET_COL_LO   = 8'h00;
  localparam logic [7:0] CMD_SET_COL_HI   = 8'h10;
  localparam logic [7:0] CMD_ADDR_MODE    = 8'h20;
  localparam logic [7:0] CMD_COL_ADDR     = 8'h21;
  localparam logic [7:0] CMD_PAGE_ADDR    = 8'h22;
  localparam logic [7:0] CMD_SET_CONTRAST = 8'h81;
  localparam logic [7:0] CMD_CHARGE_PUMP  = 8'h8D;
  localparam logic [7:0] CMD_MUX_RATIO    = 8'hA8;
  localparam logic [7:0] CMD_DISPLAY_OFF  = 8'hAE;
  localparam logic [7:0] CMD_DISPLAY_ON   = 8'hAF;
  localparam logic [7:0] CMD_SET_PAGE     = 8'hB0;
  localparam logic [7:0] CMD_DISP_OFFSET  = 8'hD3;
  localparam logic [7:0] CMD_CLK_DIV      = 8'hD5;
  localparam logic [7:0] CMD_PRECHARGE    = 8'hD9;
  localparam logic [7:0] CMD_COM_PINS     = 8'hDA;
  localparam logic [7:0] CMD_VCOMH        = 8'hDB;

  typedef enum logic [1:0] {
    AM_HORIZ = 2'b00,
    AM_VERT  = 2'b01,
    AM_PAGE  = 2'b10
  } addr_mode_e;

  typedef enum logic [1:0] {
    DEC_IDLE = 2'd0,
    DEC_ARG1 = 2'd1,
    DEC_ARG2 = 2'd2
  } dec_state_e;

  // Number of argument bytes that follow an opcode on the command channel.
  function automatic logic [1:0] arg_count(input logic [7:0] op);
    case (op)
      CMD_COL_ADDR, CMD_PAGE_ADDR:                      return 2'd2;
      CMD_ADDR_MODE, CMD_SET_CONTRAST, CMD_CHARGE_PUMP,
      CMD_MUX_RATIO, CMD_DISP_OFFSET, CMD_CLK_DIV,
      CMD_PRECHARGE, CMD_COM_PINS, CMD_VCOMH:           return 2'd1;
      default:                                          return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// SPI mode-0 byte receiver: synchronizes csn/sck/mosi/dc, shifts MSB first, flags torn frames.
// Latency: byte_vld one cycle after the synced 8th sck rise (SYNC_STAGES+1 cycles from the raw edge).
// Backpressure: none; byte_vld is a single-cycle strobe the consumer must take.
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_in,
  input  logic       resetn_in,
  input  logic       spi_csn,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  input  logic       spi_dc,
  output logic       byte_vld,
  output logic [7:0] byte_dat,
  output logic       byte_dc,
  output logic       frame_err
);

  logic [SYNC_STAGES-1:0] csn_sync, sck_sync, mosi_sync, dc_sync;
  logic                   csn_s, sck_s, mosi_s, dc_s;
  logic                   sck_prev;
  logic                   sck_rise;
  logic [2:0]             bit_cnt;
  logic [6:0]             shift;

  assign csn_s    = csn_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign dc_s     = dc_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;

  // Resynchronize the four SPI pins; csn idles deasserted.
  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      csn_sync  <= '1;
      sck_sync  <= '0;
      mosi_sync <= '0;
      dc_sync   <= '0;
    end else begin
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], spi_dc};
    end
  end

  // Shift on sck rise inside a frame; a deselect with a partial byte drops it and latches the error.
  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      sck_prev  <= 1'b0;
      bit_cnt   <= 3'd0;
      shift     <= 7'd0;
      byte_vld  <= 1'b0;
      byte_dat  <= 8'd0;
      byte_dc   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_vld <= 1'b0;
      sck_prev <= sck_s;
      if (csn_s) begin
        bit_cnt <= 3'd0;
        if (bit_cnt != 3'd0) frame_err <= 1'b1;
      end else if (sck_rise) begin
        shift   <= {shift[5:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_vld <= 1'b1;
          byte_dat <= {shift, mosi_s};
          byte_dc  <= dc_s;
        end
      end
    end
  end

endmodule

// File: rtl/ssd1306_spi_sink.sv
// SSD1306 controller model: decodes SPI command bytes and turns data bytes into framebuffer writes.
// Latency: fb_we/cmd_valid one cycle after byte_vld (SYNC_STAGES+2 cycles from the raw 8th sck edge).
// Backpressure: none; the framebuffer must accept every fb_we strobe.
module ssd1306_spi_sink
  import ssd1306_pkg::*;
#(
  parameter int COLS        = 128,
  parameter int PAGES       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                           clk_in,
  input  logic                           resetn_in,
  input  logic                           spi_csn,
  input  logic                           spi_sck,
  input  logic                           spi_mosi,
  input  logic                           spi_dc,
  output logic                           fb_we,
  output logic [$clog2(COLS*PAGES)-1:0]  fb_addr,
  output logic [7:0]                     fb_data,
  output logic                           cmd_valid,
  output logic [7:0]                     cmd_byte,
  output logic                           display_on,
  output logic [7:0]                     contrast,
  output logic [1:0]                     addr_mode,
  output logic                           frame_err
);

  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(PAGES);
  localparam int AW = $clog2(COLS*PAGES);
  localparam logic [CW-1:0] COL_MAX  = CW'(COLS - 1);
  localparam logic [PW-1:0] PAGE_MAX = PW'(PAGES - 1);

  logic       byte_vld;
  logic [7:0] byte_dat;
  logic       byte_dc;

  spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk_in    (clk_in),
    .resetn_in (resetn_in),
    .spi_csn   (spi_csn),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .spi_dc    (spi_dc),
    .byte_vld  (byte_vld),
    .byte_dat  (byte_dat),
    .byte_dc   (byte_dc),
    .frame_err (frame_err)
  );

  dec_state_e    state_q, state_d;
  addr_mode_e    mode_q, mode_d;
  logic [7:0]    op_q, op_d;
  logic [CW-1:0] col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d, pm_q, pm_d;
  logic [PW-1:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
  logic          on_q, on_d;
  logic [7:0]    contrast_q, contrast_d;
  logic          we_q, we_d, cv_q, cv_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    data_q, data_d, cb_q, cb_d;
  logic          col_last, page_last;

  // A pointer wraps to its window start at the window end, or at the top index when start > end.
  assign col_last  = (col_q == col_end_q) || (col_q == COL_MAX);
  assign page_last = (page_q == page_end_q) || (page_q == PAGE_MAX);

  // Decoder next-state: opcode/argument effects for command bytes, write + pointer advance for data.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    op_d         = op_q;
    col_d        = col_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    pm_d         = pm_q;
    page_d       = page_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    on_d         = on_q;
    contrast_d   = contrast_q;
    we_d         = 1'b0;
    cv_d         = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    cb_d         = cb_q;
    if (byte_vld) begin
      if (byte_dc) begin
        // Data aborts any half-received command.
        state_d = DEC_IDLE;
        we_d    = 1'b1;
        addr_d  = {page_q, col_q};
        data_d  = byte_dat;
        case (mode_q)
          AM_HORIZ: begin
            if (col_last) begin
              col_d  = col_start_q;
              page_d = page_last ? page_start_q : page_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
          AM_VERT: begin
            if (page_last) begin
              page_d = page_start_q;
              col_d  = col_last ? col_start_q : col_q + 1'b1;
            end else begin
              page_d = page_q + 1'b1;
            end
          end
          default: col_d = (col_q == COL_MAX) ? pm_q : col_q + 1'b1;
        endcase
      end else begin
        cv_d = 1'b1;
        cb_d = byte_dat;
        case (state_q)
          DEC_IDLE: begin
            op_d = byte_dat;
            if (arg_count(byte_dat) != 2'd0) state_d = DEC_ARG1;
            if (byte_dat == CMD_DISPLAY_OFF || byte_dat == CMD_DISPLAY_ON) on_d = byte_dat[0];
            if ((byte_dat & 8'hF8) == CMD_SET_PAGE) page_d = PW'(byte_dat[2:0]);
            if ((byte_dat & 8'hF0) == CMD_SET_COL_LO) begin
              col_d = (col_q & ~CW'(15)) | CW'(byte_dat[3:0]);
              pm_d  = (pm_q & ~CW'(15)) | CW'(byte_dat[3:0]);
            end
            if ((byte_dat & 8'hF0) == CMD_SET_COL_HI) begin
              col_d = (col_q & CW'(15)) | CW'({byte_dat[3:0], 4'h0});
              pm_d  = (pm_q & CW'(15)) | CW'({byte_dat[3:0], 4'h0});
            end
          end
          DEC_ARG1: begin
            state_d = (arg_count(op_q) == 2'd2) ? DEC_ARG2 : DEC_IDLE;
            case (op_q)
              CMD_ADDR_MODE:    if (byte_dat[1:0] != 2'b11) mode_d = addr_mode_e'(byte_dat[1:0]);
              CMD_SET_CONTRAST: contrast_d = byte_dat;
              CMD_COL_ADDR:     col_start_d = byte_dat[CW-1:0];
              CMD_PAGE_ADDR:    page_start_d = byte_dat[PW-1:0];
              default: ;
            endcase
          end
          DEC_ARG2: begin
            state_d = DEC_IDLE;
            case (op_q)
              CMD_COL_ADDR: begin
                col_end_d = byte_dat[CW-1:0];
                col_d     = col_start_q;
              end
              CMD_PAGE_ADDR: begin
                page_end_d = byte_dat[PW-1:0];
                page_d     = page_start_q;
              end
              default: ;
            endcase
          end
          default: state_d = DEC_IDLE;
        endcase
      end
    end
  end

  // Decoder, pointer and output registers.
  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      state_q      <= DEC_IDLE;
      mode_q       <= AM_PAGE;
      op_q         <= 8'd0;
      col_q        <= '0;
      col_start_q  <= '0;
      col_end_q    <= COL_MAX;
      pm_q         <= '0;
      page_q       <= '0;
      page_start_q <= '0;
      page_end_q   <= PAGE_MAX;
      on_q         <= 1'b0;
      contrast_q   <= 8'h7F;
      we_q         <= 1'b0;
      cv_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= 8'd0;
      cb_q         <= 8'd0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      op_q         <= op_d;
      col_q        <= col_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      pm_q         <= pm_d;
      page_q       <= page_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      on_q         <= on_d;
      contrast_q   <= contrast_d;
      we_q         <= we_d;
      cv_q         <= cv_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      cb_q         <= cb_d;
    end
  end

  assign fb_we      = we_q;
  assign fb_addr    = addr_q;
  assign fb_data    = data_q;
  assign cmd_valid  = cv_q;
  assign cmd_byte   = cb_q;
  assign display_on = on_q;
  assign contrast   = contrast_q;
  assign addr_mode  = mode_q;

endmodule

// File: tb/tb_ssd1306_spi_sink.sv
// Bench for ssd1306_spi_sink: directed link scenarios followed by random command/data traffic.
// Expected writes, command echoes and register state come from a byte-level controller model.
// Outputs are sampled on the falling clock edge.
module tb_ssd1306_spi_sink;

  localparam int COLS  = 128;
  localparam int PAGES = 8;
  localparam int SYNC  = 2;

  logic       clk_in = 1'b0;
  logic       resetn_in = 1'b0;
  logic       spi_csn = 1'b1;
  logic       spi_sck = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_dc = 1'b0;
  logic       fb_we;
  logic [9:0] fb_addr;
  logic [7:0] fb_data;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic       display_on;
  logic [7:0] contrast;
  logic [1:0] addr_mode;
  logic       frame_err;

  always #5 clk_in = ~clk_in;

  ssd1306_spi_sink #(.COLS(COLS), .PAGES(PAGES), .SYNC_STAGES(SYNC)) dut (
    .clk_in     (clk_in),
    .resetn_in  (resetn_in),
    .spi_csn    (spi_csn),
    .spi_sck    (spi_sck),
    .spi_mosi   (spi_mosi),
    .spi_dc     (spi_dc),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .cmd_valid  (cmd_valid),
    .cmd_byte   (cmd_byte),
    .display_on (display_on),
    .contrast   (contrast),
    .addr_mode  (addr_mode),
    .frame_err  (frame_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model (byte level) ----------------
  int m_col = 0, m_page = 0, m_cs = 0, m_ce = COLS - 1, m_ps = 0, m_pe = PAGES - 1, m_pm = 0;
  int m_mode = 2, m_contrast = 127, m_on = 0, m_ferr = 0;
  int m_op = 0, m_pend = 0, m_argi = 0;
  int exp_addr[$];
  int exp_data[$];
  int exp_cmd[$];

  function automatic void model_advance();
    bit cl, pl;
    cl = (m_col == m_ce) || (m_col == COLS - 1);
    pl = (m_page == m_pe) || (m_page == PAGES - 1);
    if (m_mode == 0) begin
      if (cl) begin
        m_col  = m_cs;
        m_page = pl ? m_ps : m_page + 1;
      end else m_col = m_col + 1;
    end else if (m_mode == 1) begin
      if (pl) begin
        m_page = m_ps;
        m_col  = cl ? m_cs : m_col + 1;
      end else m_page = m_page + 1;
    end else begin
      m_col = (m_col == COLS - 1) ? m_pm : m_col + 1;
    end
  endfunction

  function automatic void model_byte(input bit dc, input int b);
    if (dc) begin
      m_pend = 0;
      exp_addr.push_back(m_page * COLS + m_col);
      exp_data.push_back(b);
      model_advance();
    end else begin
      exp_cmd.push_back(b);
      if (m_pend == 0) begin
        m_op = b;
        m_argi = 0;
        if (b == 'h21 || b == 'h22) m_pend = 2;
        else if (b inside {'h20, 'h81, 'h8D, 'hA8, 'hD3, 'hD5, 'hD9, 'hDA, 'hDB}) m_pend = 1;
        if (b == 'hAE) m_on = 0;
        if (b == 'hAF) m_on = 1;
        if (b >= 'hB0 && b <= 'hB7) m_page = (b - 'hB0) % PAGES;
        if (b <= 'h0F) begin
          m_col = m_col - (m_col % 16) + (b % 16);
          m_pm  = m_pm - (m_pm % 16) + (b % 16);
        end
        if (b >= 'h10 && b <= 'h1F) begin
          m_col = ((b % 16) * 16 + m_col % 16) % COLS;
          m_pm  = ((b % 16) * 16 + m_pm % 16) % COLS;
        end
      end else begin
        if (m_argi == 0) begin
          if (m_op == 'h20 && (b % 4) != 3) m_mode = b % 4;
          if (m_op == 'h81) m_contrast = b;
          if (m_op == 'h21) m_cs = b % COLS;
          if (m_op == 'h22) m_ps = b % PAGES;
        end else begin
          if (m_op == 'h21) begin m_ce = b % COLS;  m_col = m_cs; end
          if (m_op == 'h22) begin m_pe = b % PAGES; m_page = m_ps; end
        end
        m_argi++;
        m_pend--;
      end
    end
  endfunction

  // ---------------- output monitor ----------------
  always @(negedge clk_in) begin
    if (resetn_in) begin
      if (fb_we) begin
        if (exp_addr.size() == 0) chk("fb_we_spurious", 32'd1, 32'd0);
        else begin
          chk("fb_addr", 32'(fb_addr), exp_addr.pop_front());
          chk("fb_data", 32'(fb_data), exp_data.pop_front());
        end
      end
      if (cmd_valid) begin
        if (exp_cmd.size() == 0) chk("cmd_valid_spurious", 32'd1, 32'd0);
        else chk("cmd_byte", 32'(cmd_byte), exp_cmd.pop_front());
      end
    end
  end

  // ---------------- SPI driver ----------------
  task automatic spi_bits(input bit dc, input logic [7:0] b, input int nbits, input bit raise);
    if (spi_csn) begin
      @(negedge clk_in) spi_csn = 1'b0;
      repeat (3) @(negedge clk_in);
    end
    spi_dc = dc;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = b[7 - i];
      repeat (4) @(negedge clk_in);
      spi_sck = 1'b1;
      repeat (4) @(negedge clk_in);
      spi_sck = 1'b0;
    end
    repeat (2) @(negedge clk_in);
    if (raise) begin
      spi_csn = 1'b1;
      repeat (8) @(negedge clk_in);
    end
  endtask

  task automatic check_state();
    chk("display_on", 32'(display_on), m_on);
    chk("contrast",   32'(contrast),   m_contrast);
    chk("addr_mode",  32'(addr_mode),  m_mode);
    chk("frame_err",  32'(frame_err),  m_ferr);
  endtask

  task automatic send_byte(input bit dc, input logic [7:0] b, input bit raise);
    model_byte(dc, int'(b));
    spi_bits(dc, b, 8, raise);
    repeat (6) @(negedge clk_in);
    check_state();
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    spi_bits(1'b0, b, nbits, 1'b1);
    m_ferr = 1;
    check_state();
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] ops [13];
  logic [7:0] bv;
  int         r;

  initial begin
    ops = '{8'h20, 8'h21, 8'h22, 8'h81, 8'hAE, 8'hAF, 8'hB0, 8'h00, 8'h10, 8'h8D, 8'hA8, 8'hD3, 8'hE3};

    repeat (4) @(negedge clk_in);
    chk("rst_fb_we",      32'(fb_we),      32'd0);
    chk("rst_fb_addr",    32'(fb_addr),    32'd0);
    chk("rst_fb_data",    32'(fb_data),    32'd0);
    chk("rst_cmd_valid",  32'(cmd_valid),  32'd0);
    chk("rst_cmd_byte",   32'(cmd_byte),   32'd0);
    chk("rst_display_on", 32'(display_on), 32'd0);
    chk("rst_contrast",   32'(contrast),   32'h7F);
    chk("rst_addr_mode",  32'(addr_mode),  32'd2);
    chk("rst_frame_err",  32'(frame_err),  32'd0);
    resetn_in = 1'b1;
    repeat (4) @(negedge clk_in);

    // Page mode from reset: consecutive columns on page 0.
    send_byte(1'b1, 8'h11, 1'b0);
    send_byte(1'b1, 8'h22, 1'b0);
    send_byte(1'b1, 8'h33, 1'b1);

    // Horizontal mode inside a 2x2 window.
    send_byte(1'b0, 8'h20, 1'b1);
    send_byte(1'b0, 8'h00, 1'b1);
    send_byte(1'b0, 8'h21, 1'b0);
    send_byte(1'b0, 8'd126, 1'b0);
    send_byte(1'b0, 8'd127, 1'b1);
    send_byte(1'b0, 8'h22, 1'b1);
    send_byte(1'b0, 8'd6, 1'b1);
    send_byte(1'b0, 8'd7, 1'b1);
    for (int i = 0; i < 5; i++) send_byte(1'b1, 8'hA0 + 8'(i), i == 4);

    // Torn argument byte keeps the decoder waiting for the contrast value.
    send_byte(1'b0, 8'h81, 1'b1);
    send_partial(8'hFF, 6);
    chk("frame_err_set", 32'(frame_err), 32'd1);
    send_byte(1'b0, 8'h40, 1'b1);
    chk("contrast_after_tear", 32'(contrast), 32'h40);

    // Display on/off.
    send_byte(1'b0, 8'hAF, 1'b1);
    chk("display_on_set", 32'(display_on), 32'd1);
    send_byte(1'b0, 8'hAE, 1'b1);
    chk("display_on_clr", 32'(display_on), 32'd0);

    // Page mode column wrap to the page-mode start column.
    send_byte(1'b0, 8'h20, 1'b0);
    send_byte(1'b0, 8'h02, 1'b0);
    send_byte(1'b0, 8'hB3, 1'b0);
    send_byte(1'b0, 8'h05, 1'b0);
    send_byte(1'b0, 8'h17, 1'b1);
    for (int i = 0; i < 12; i++) send_byte(1'b1, 8'(i * 7 + 1), 1'b0);

    // Data aborts a pending column-address command; next command byte is an opcode.
    send_byte(1'b0, 8'h21, 1'b1);
    send_byte(1'b1, 8'hAA, 1'b1);
    send_byte(1'b0, 8'hAF, 1'b1);
    chk("abort_then_opcode", 32'(display_on), 32'd1);

    // Random traffic.
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        send_partial(8'($urandom), $urandom_range(1, 7));
      end else if (r < 45) begin
        send_byte(1'b1, 8'($urandom), $urandom_range(0, 3) != 0);
      end else begin
        if (m_pend > 0) bv = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
        else begin
          bv = ops[$urandom_range(0, 12)];
          if (bv == 8'hB0) bv = bv | 8'($urandom_range(0, 7));
          if (bv == 8'h00 || bv == 8'h10) bv = bv | 8'($urandom_range(0, 15));
        end
        send_byte(1'b0, bv, $urandom_range(0, 3) != 0);
      end
    end

    spi_csn = 1'b1;
    repeat (20) @(negedge clk_in);
    chk("writes_drained",   32'(exp_addr.size()), 32'd0);
    chk("commands_drained", 32'(exp_cmd.size()),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
